// File: rtl/pio_read_arbiter.sv
// pio_read_arbiter
// Purpose: shares one PIO-style read slave between two requesters.
//   Round-robin arbitration on contention. At most one access is in flight.
//   Accept -> WAIT (READ_LATENCY cycles) -> CAPTURE -> response strobe.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   mX_read / mX_address       requester X read request and word address
//   mX_waitrequest             low only in the cycle requester X is accepted
//   mX_readdata / mX_readdatavalid  registered response data and 1-cycle strobe
//   s_address / s_read         registered slave address, high while in WAIT
//   s_readdata                 slave read data, sampled in CAPTURE
//   busy                       high whenever the FSM is not IDLE
module pio_read_arbiter #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_read,
  input  logic [ADDR_W-1:0] m0_address,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic [ADDR_W-1:0] m1_address,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  input  logic [DATA_W-1:0] s_readdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  // Last WAIT cycle index; the counter starts at 0 on accept.
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last_grant;  // 1 = m1 was granted most recently
  logic              r_winner;      // requester owning the in-flight access
  logic [1:0]        r_lat_cnt;
  logic [ADDR_W-1:0] r_s_address;
  logic [DATA_W-1:0] r_m0_readdata;
  logic [DATA_W-1:0] r_m1_readdata;
  logic              r_m0_valid;
  logic              r_m1_valid;
  logic              w_grant_m0;
  logic              w_grant_m1;

  // Next state and combinational grant. Grants are suppressed during
  // reset so both waitrequests read high while reset is asserted.
  always_comb begin
    w_state_next = r_state;
    w_grant_m0   = 1'b0;
    w_grant_m1   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!reset) begin
          if (m0_read && m1_read) begin
            // Contention: favour whoever was not granted last.
            w_grant_m0 = r_last_grant;
            w_grant_m1 = ~r_last_grant;
          end else begin
            w_grant_m0 = m0_read;
            w_grant_m1 = m1_read;
          end
          if (w_grant_m0 || w_grant_m1) begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last_grant  <= 1'b1;
      r_winner      <= 1'b0;
      r_lat_cnt     <= 2'd0;
      r_s_address   <= '0;
      r_m0_readdata <= '0;
      r_m1_readdata <= '0;
      r_m0_valid    <= 1'b0;
      r_m1_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_m0_valid <= 1'b0;
      r_m1_valid <= 1'b0;
      if (w_grant_m0 || w_grant_m1) begin
        // Address is captured here so later requester address changes
        // cannot disturb the access already in flight.
        r_s_address  <= w_grant_m1 ? m1_address : m0_address;
        r_winner     <= w_grant_m1;
        r_last_grant <= w_grant_m1;
        r_lat_cnt    <= 2'd0;
      end
      if (r_state == WAIT) begin
        r_lat_cnt <= r_lat_cnt + 2'd1;
      end
      if (r_state == CAPTURE) begin
        if (r_winner) begin
          r_m1_readdata <= s_readdata;
          r_m1_valid    <= 1'b1;
        end else begin
          r_m0_readdata <= s_readdata;
          r_m0_valid    <= 1'b1;
        end
      end
    end
  end

  assign m0_waitrequest   = ~w_grant_m0;
  assign m1_waitrequest   = ~w_grant_m1;
  assign m0_readdata      = r_m0_readdata;
  assign m1_readdata      = r_m1_readdata;
  assign m0_readdatavalid = r_m0_valid;
  assign m1_readdatavalid = r_m1_valid;
  assign s_address        = r_s_address;
  assign s_read           = (r_state == WAIT);
  assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_pio_read_arbiter.sv
module tb_pio_read_arbiter;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              m0_read = 1'b0;
  logic [ADDR_W-1:0] m0_address = '0;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;
  logic              m1_read = 1'b0;
  logic [ADDR_W-1:0] m1_address = '0;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;
  logic [ADDR_W-1:0] s_address;
  logic              s_read;
  logic [DATA_W-1:0] s_readdata = '0;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  // Slave: four words, word 2 undecoded (reads as zero), registered read.
  logic [DATA_W-1:0] mem [4];
  initial begin
    mem[0] = 32'h0000_0001;
    mem[1] = 32'hA5A5_0001;
    mem[2] = 32'h0000_0000;
    mem[3] = 32'h1234_5678;
  end
  always @(posedge clk) s_readdata <= mem[s_address];

  always #5 clk = ~clk;

  pio_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_readdata(s_readdata), .busy(busy)
  );

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    m0_read = 1'b1; m1_read = 1'b1;
    #1;
    n_checks++; if (m0_waitrequest !== 1'b1) begin n_errors++; $display("FAIL reset_m0_wait got %b exp 1", m0_waitrequest); end
    n_checks++; if (m1_waitrequest !== 1'b1) begin n_errors++; $display("FAIL reset_m1_wait got %b exp 1", m1_waitrequest); end
    n_checks++; if ({busy, s_read, m0_readdatavalid, m1_readdatavalid} !== 4'b0000) begin n_errors++; $display("FAIL reset_flags got %b exp 0000", {busy, s_read, m0_readdatavalid, m1_readdatavalid}); end
    n_checks++; if (s_address !== 2'd0) begin n_errors++; $display("FAIL reset_s_address got %0d exp 0", s_address); end
    n_checks++; if ({m0_readdata, m1_readdata} !== 64'd0) begin n_errors++; $display("FAIL reset_readdata got %h exp 0", {m0_readdata, m1_readdata}); end
    m0_read = 1'b0; m1_read = 1'b0;
    reset = 1'b0;
    tick();
    $display("reset: done");
  endtask

  task automatic test_single_read();
    // cycle 0: accept m0 at address 0
    m0_read = 1'b1; m0_address = 2'd0;
    #1;
    n_checks++; if (m0_waitrequest !== 1'b0) begin n_errors++; $display("FAIL single_accept got %b exp 0", m0_waitrequest); end
    n_checks++; if (m1_waitrequest !== 1'b1) begin n_errors++; $display("FAIL single_m1_wait got %b exp 1", m1_waitrequest); end
    // cycle 1: in WAIT; address change must not affect the access
    tick();
    m0_read = 1'b0; m0_address = 2'd3;
    #1;
    n_checks++; if ({busy, s_read, m0_waitrequest} !== 3'b111) begin n_errors++; $display("FAIL single_wait_state got %b exp 111", {busy, s_read, m0_waitrequest}); end
    n_checks++; if (s_address !== 2'd0) begin n_errors++; $display("FAIL single_s_address got %0d exp 0", s_address); end
    // cycle 2: CAPTURE
    tick(); #1;
    n_checks++; if ({busy, s_read, m0_readdatavalid} !== 3'b100) begin n_errors++; $display("FAIL single_capture got %b exp 100", {busy, s_read, m0_readdatavalid}); end
    // cycle 3: response
    tick(); #1;
    n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h1) begin n_errors++; $display("FAIL single_resp got v=%b d=%h exp v=1 d=00000001", m0_readdatavalid, m0_readdata); end
    n_checks++; if (m1_readdatavalid !== 1'b0 || m1_readdata !== 32'h0) begin n_errors++; $display("FAIL single_m1_unchanged got v=%b d=%h exp v=0 d=0", m1_readdatavalid, m1_readdata); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
    // cycle 4: strobe is one cycle, data holds
    tick(); #1;
    n_checks++; if (m0_readdatavalid !== 1'b0 || m0_readdata !== 32'h1) begin n_errors++; $display("FAIL single_hold got v=%b d=%h exp v=0 d=00000001", m0_readdatavalid, m0_readdata); end
    $display("single_read: m0 addr 0 -> %h", m0_readdata);
  endtask

  task automatic test_contention();
    do_reset();
    // cycle 0: both request, m0 wins after reset
    m0_read = 1'b1; m0_address = 2'd3;
    m1_read = 1'b1; m1_address = 2'd1;
    #1;
    n_checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin n_errors++; $display("FAIL cont_c0_wait got %b exp 01", {m0_waitrequest, m1_waitrequest}); end
    tick(); m0_read = 1'b0; #1;
    n_checks++; if (m1_waitrequest !== 1'b1) begin n_errors++; $display("FAIL cont_c1_m1_wait got %b exp 1", m1_waitrequest); end
    tick(); #1;
    tick(); #1;
    // cycle 3: m0 response and m1 accept in the same cycle
    n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h1234_5678) begin n_errors++; $display("FAIL cont_m0_resp got v=%b d=%h exp v=1 d=12345678", m0_readdatavalid, m0_readdata); end
    n_checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b10) begin n_errors++; $display("FAIL cont_c3_wait got %b exp 10", {m0_waitrequest, m1_waitrequest}); end
    tick(); m1_read = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    // cycle 6: m1 response, m0 data untouched
    n_checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hA5A5_0001) begin n_errors++; $display("FAIL cont_m1_resp got v=%b d=%h exp v=1 d=a5a50001", m1_readdatavalid, m1_readdata); end
    n_checks++; if (m0_readdatavalid !== 1'b0 || m0_readdata !== 32'h1234_5678) begin n_errors++; $display("FAIL cont_m0_hold got v=%b d=%h exp v=0 d=12345678", m0_readdatavalid, m0_readdata); end
    tick();
    $display("contention: m0=%h m1=%h", m0_readdata, m1_readdata);
  endtask

  task automatic test_sustained();
    // last grant was m1, so m0 wins first; accepts at 0,3,6,9 alternate.
    for (int k = 0; k < 12; k++) begin
      m0_read = 1'b1; m0_address = 2'd0;
      m1_read = 1'b1; m1_address = 2'd1;
      #1;
      n_checks++;
      if (m0_waitrequest !== !(k % 6 == 0) || m1_waitrequest !== !(k % 6 == 3) || busy !== (k % 3 != 0)) begin
        n_errors++;
        $display("FAIL sust_k%0d got w0=%b w1=%b busy=%b exp w0=%b w1=%b busy=%b", k, m0_waitrequest, m1_waitrequest, busy,
                 !(k % 6 == 0), !(k % 6 == 3), (k % 3 != 0));
      end
      n_checks++;
      if (m0_readdatavalid !== (k == 3 || k == 9) || m1_readdatavalid !== (k == 6)) begin
        n_errors++;
        $display("FAIL sust_valid_k%0d got v0=%b v1=%b exp v0=%b v1=%b", k, m0_readdatavalid, m1_readdatavalid, (k == 3 || k == 9), (k == 6));
      end
      tick();
    end
    m0_read = 1'b0; m1_read = 1'b0;
    #1;
    n_checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hA5A5_0001) begin n_errors++; $display("FAIL sust_last_resp got v=%b d=%h exp v=1 d=a5a50001", m1_readdatavalid, m1_readdata); end
    tick();
    $display("sustained: 12 cycles of contention");
  endtask

  task automatic test_undecoded();
    m0_read = 1'b1; m0_address = 2'd2;
    #1;
    n_checks++; if (m0_readdata !== 32'h1) begin n_errors++; $display("FAIL undec_prior got %h exp 00000001", m0_readdata); end
    n_checks++; if (m0_waitrequest !== 1'b0) begin n_errors++; $display("FAIL undec_accept got %b exp 0", m0_waitrequest); end
    tick(); m0_read = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0) begin n_errors++; $display("FAIL undec_resp got v=%b d=%h exp v=1 d=0", m0_readdatavalid, m0_readdata); end
    tick();
    $display("undecoded: m0 addr 2 -> %h", m0_readdata);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 9; k++) begin
      m1_read = 1'b1; m1_address = 2'd3;
      #1;
      n_checks++;
      if (m1_waitrequest !== (k % 3 != 0) || busy !== (k % 3 != 0) || m0_waitrequest !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_k%0d got w1=%b busy=%b w0=%b exp w1=%b busy=%b w0=1", k, m1_waitrequest, busy, m0_waitrequest, (k % 3 != 0), (k % 3 != 0));
      end
      n_checks++;
      if (m1_readdatavalid !== (k == 3 || k == 6)) begin
        n_errors++;
        $display("FAIL b2b_valid_k%0d got %b exp %b", k, m1_readdatavalid, (k == 3 || k == 6));
      end
      tick();
    end
    m1_read = 1'b0;
    #1;
    n_checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h1234_5678) begin n_errors++; $display("FAIL b2b_last_resp got v=%b d=%h exp v=1 d=12345678", m1_readdatavalid, m1_readdata); end
    tick();
    $display("back_to_back: m1 three accesses");
  endtask

  task automatic test_reset_mid();
    m0_read = 1'b1; m0_address = 2'd3;
    #1;
    n_checks++; if (m0_waitrequest !== 1'b0) begin n_errors++; $display("FAIL rmid_accept got %b exp 0", m0_waitrequest); end
    // cycle 1: reset during WAIT
    tick();
    m0_read = 1'b1; reset = 1'b1;
    #1;
    n_checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin n_errors++; $display("FAIL rmid_wait_in_reset got %b exp 11", {m0_waitrequest, m1_waitrequest}); end
    tick();
    reset = 1'b0; m0_read = 1'b0;
    for (int k = 2; k < 6; k++) begin
      #1;
      n_checks++;
      if (m0_readdatavalid !== 1'b0 || m0_readdata !== 32'h0 || busy !== 1'b0 || s_address !== 2'd0 || s_read !== 1'b0) begin
        n_errors++;
        $display("FAIL rmid_c%0d got v=%b d=%h busy=%b sa=%0d sr=%b exp v=0 d=0 busy=0 sa=0 sr=0", k, m0_readdatavalid, m0_readdata, busy, s_address, s_read);
      end
      tick();
    end
    $display("reset_mid: access aborted");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_sustained();
    test_undecoded();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
